// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: samples WIDTH toggle-hit strobes into pending and
// covered bitmaps, then drains pending hits one global cover index per cycle
// (round-robin from the last served bit) through a small show-ahead FIFO.
//
// Report port handshake: report_valid means the FIFO head holds a report and
// report_index carries it. The head is consumed on a clock edge where
// report_valid && report_ready. report_valid never depends on report_ready.
// report_index holds steady while report_valid && !report_ready.
module cover_toggle_collector #(
    parameter int WIDTH       = 6,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 28338,
    parameter int FIFO_DEPTH  = 4,
    parameter bit FIRST_ONLY  = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             valid,
    output logic                         report_valid,
    input  logic                         report_ready,
    output logic [63:0]                  report_index,
    output logic [$clog2(WIDTH+1)-1:0]   covered_count,
    output logic [15:0]                  drop_count
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;

    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] covered;
    logic [PW-1:0]    rr_ptr;

    logic [PW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [NW-1:0]    count;

    logic             fifo_full;
    logic             pop;
    logic             can_push;
    logic             sel_found;
    logic [PW-1:0]    sel_idx;
    logic [WIDTH-1:0] pop_sel;
    logic [WIDTH-1:0] hit;
    logic [CW-1:0]    drop_inc;
    logic [16:0]      drop_sum;
    logic [15:0]      drop_next;

    assign fifo_full    = (count == NW'(FIFO_DEPTH));
    assign report_valid = (count != '0);
    assign pop          = report_valid & report_ready;
    // A slot frees up this edge if the head is popped, so a full FIFO can
    // still accept a push while draining. No push on a clear edge.
    assign can_push     = !clear && (!fifo_full || pop);

    assign hit = {WIDTH{enable & ~clear}} & valid & ~(covered & {WIDTH{FIRST_ONLY}});

    assign report_index = report_valid ? (64'(COVER_INDEX) + 64'(mem[rd_ptr])) : 64'd0;

    // Round-robin pick: first pending bit at or after rr_ptr, wrapping to 0.
    always_comb begin
        int pos;
        sel_found = 1'b0;
        sel_idx   = '0;
        pos       = 0;
        for (int k = 0; k < WIDTH; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= WIDTH) pos = pos - WIDTH;
            if (!sel_found && can_push && pending[pos]) begin
                sel_found = 1'b1;
                sel_idx   = PW'(pos);
            end
        end
    end

    // One-hot form of the selection, used to retire the served pending bit.
    always_comb begin
        pop_sel = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_sel[i] = sel_found && (sel_idx == PW'(i));
        end
    end

    // Hits landing on a bit that is already pending and not being served are
    // coalesced; count them (saturating) when every hit is to be reported.
    always_comb begin
        drop_inc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            drop_inc = drop_inc + CW'(hit[i] & pending[i] & ~pop_sel[i]);
        end
        drop_sum  = {1'b0, drop_count} + 17'(drop_inc);
        drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Popcount of the covered bitmap.
    always_comb begin
        covered_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            covered_count = covered_count + CW'(covered[i]);
        end
    end

    // Pending/covered bitmaps, drop counter and round-robin pointer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending    <= '0;
            covered    <= '0;
            drop_count <= '0;
            rr_ptr     <= '0;
        end else if (clear) begin
            pending    <= '0;
            covered    <= '0;
            drop_count <= '0;
        end else begin
            pending    <= hit | (pending & ~pop_sel);
            covered    <= covered | hit;
            drop_count <= FIRST_ONLY ? 16'd0 : drop_next;
            if (sel_found) begin
                rr_ptr <= (sel_idx == PW'(WIDTH - 1)) ? '0 : sel_idx + PW'(1);
            end
        end
    end

    // FIFO storage keeps only the local bit index; the offset is added at the head.
    always_ff @(posedge clock) begin
        if (sel_found) mem[wr_ptr] <= sel_idx;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (sel_found) wr_ptr <= wr_ptr + AW'(1);
            if (pop)       rd_ptr <= rd_ptr + AW'(1);
            case ({sel_found, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Bench for cover_toggle_collector: two instances (FIRST_ONLY=1 and =0),
// a queue-based reference model per instance, directed scenarios, then
// randomized traffic with occasional clears and resets.
module tb_cover_toggle_collector;

  localparam int W  = 6;
  localparam int CI = 100;
  localparam int D  = 4;

  logic        clock;
  logic        reset;
  logic [1:0]  en;
  logic [1:0]  clr;
  logic [1:0]  rdy;
  logic [W-1:0] vld [2];
  logic [1:0]  rv;
  logic [63:0] ri [2];
  logic [2:0]  cc [2];
  logic [15:0] dc [2];

  int vectors;
  int miscompares;

  // reference model state
  logic [W-1:0] m_pend [2];
  logic [W-1:0] m_cov  [2];
  int           m_rr   [2];
  int           m_drop [2];
  logic [63:0]  exp_q0 [$];
  logic [63:0]  exp_q1 [$];

  cover_toggle_collector #(.WIDTH(W), .COVER_INDEX(CI), .FIFO_DEPTH(D), .FIRST_ONLY(1'b1)) u0 (
    .clock(clock), .reset(reset), .enable(en[0]), .clear(clr[0]), .valid(vld[0]),
    .report_valid(rv[0]), .report_ready(rdy[0]), .report_index(ri[0]),
    .covered_count(cc[0]), .drop_count(dc[0]));

  cover_toggle_collector #(.WIDTH(W), .COVER_INDEX(CI), .FIFO_DEPTH(D), .FIRST_ONLY(1'b0)) u1 (
    .clock(clock), .reset(reset), .enable(en[1]), .clear(clr[1]), .valid(vld[1]),
    .report_valid(rv[1]), .report_ready(rdy[1]), .report_index(ri[1]),
    .covered_count(cc[1]), .drop_count(dc[1]));

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int q_size(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [63:0] q_head(input int k);
    if (q_size(k) == 0) return 64'd0;
    return (k == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic q_push(input int k, input logic [63:0] v);
    if (k == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
  endtask

  task automatic q_pop(input int k);
    if (k == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
  endtask

  function automatic int popc(input logic [W-1:0] b);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(b[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = '0; m_cov[k] = '0; m_rr[k] = 0; m_drop[k] = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Advance the model across one clock edge with the currently driven inputs.
  task automatic model_step(input int k);
    bit fo = (k == 0);
    int sz = q_size(k);
    bit pop = (sz > 0) && rdy[k];
    bit space = (sz < D) || pop;
    int sel = -1;
    int nd = 0;
    logic [W-1:0] hit;
    if (!clr[k] && m_pend[k] != '0 && space) begin
      for (int o = 0; o < W; o++) begin
        int p = (m_rr[k] + o) % W;
        if (sel < 0 && m_pend[k][p]) sel = p;
      end
    end
    for (int i = 0; i < W; i++)
      hit[i] = en[k] && vld[k][i] && !clr[k] && !(fo && m_cov[k][i]);
    if (!fo)
      for (int i = 0; i < W; i++)
        if (hit[i] && m_pend[k][i] && i != sel) nd++;
    if (pop) q_pop(k);
    if (sel >= 0) begin
      q_push(k, 64'(CI + sel));
      m_rr[k] = (sel + 1) % W;
    end
    if (clr[k]) begin
      m_pend[k] = '0; m_cov[k] = '0; m_drop[k] = 0;
    end else begin
      for (int i = 0; i < W; i++)
        m_pend[k][i] = hit[i] || (m_pend[k][i] && i != sel);
      m_cov[k] = m_cov[k] | hit;
      m_drop[k] = (m_drop[k] + nd > 65535) ? 65535 : m_drop[k] + nd;
    end
  endtask

  task automatic check_outputs(input int k);
    check($sformatf("u%0d.report_valid", k), 64'(rv[k]), 64'(q_size(k) > 0));
    check($sformatf("u%0d.report_index", k), ri[k], q_head(k));
    check($sformatf("u%0d.covered_count", k), 64'(cc[k]), 64'(popc(m_cov[k])));
    check($sformatf("u%0d.drop_count", k), 64'(dc[k]), 64'(m_drop[k]));
  endtask

  // driver: one clock with current inputs, then compare both instances
  task automatic step();
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 2; k++) check_outputs(k);
  endtask

  task automatic drive(input logic e, input logic c, input logic [W-1:0] v, input logic r);
    for (int k = 0; k < 2; k++) begin
      en[k] = e; clr[k] = c; vld[k] = v; rdy[k] = r;
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0);
    reset = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) check_outputs(k);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int n;
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    model_reset();
    repeat (2) @(negedge clock);
    for (int k = 0; k < 2; k++) check_outputs(k);
    reset = 1'b1;

    // single hit, 2-cycle latency, first-only suppression
    drive(1'b1, 1'b0, 6'b000001, 1'b1);
    step();
    check("t1_no_report_yet", 64'(rv[0]), 64'd0);
    drive(1'b1, 1'b0, '0, 1'b1);
    step();
    check("t1_valid", 64'(rv[0]), 64'd1);
    check("t1_index", ri[0], 64'd100);
    step();
    check("t1_drained", 64'(rv[0]), 64'd0);
    check("t1_covered", 64'(cc[0]), 64'd1);
    drive(1'b1, 1'b0, 6'b000001, 1'b1);
    step();
    drive(1'b1, 1'b0, '0, 1'b1);
    step();
    check("t1_repeat_suppressed", 64'(rv[0]), 64'd0);
    step();

    // all bits in order
    do_reset();
    drive(1'b1, 1'b0, 6'b111111, 1'b1);
    step();
    drive(1'b1, 1'b0, '0, 1'b1);
    step();
    for (int i = 0; i < W; i++) begin
      check($sformatf("t2_index%0d", i), ri[0], 64'(CI + i));
      step();
    end
    check("t2_covered", 64'(cc[0]), 64'd6);
    check("t2_empty", 64'(rv[0]), 64'd0);

    // back-pressure: 4 queued, head stable, then drain all 6
    do_reset();
    drive(1'b1, 1'b0, 6'b111111, 1'b0);
    step();
    drive(1'b1, 1'b0, '0, 1'b0);
    repeat (6) step();
    check("t3_held_valid", 64'(rv[0]), 64'd1);
    check("t3_head_stable", ri[0], 64'd100);
    drive(1'b1, 1'b0, '0, 1'b1);
    n = 0;
    repeat (10) begin
      if (rv[0]) n++;
      step();
    end
    check("t3_total_reports", 64'(n), 64'd6);

    // coalesced hits with FIRST_ONLY=0
    do_reset();
    drive(1'b1, 1'b0, 6'b000100, 1'b0);
    repeat (10) step();
    check("t4_drops", 64'(dc[1]), 64'd5);
    drive(1'b1, 1'b0, '0, 1'b1);
    n = 0;
    repeat (10) begin
      if (rv[1]) begin
        n++;
        check("t4_index", ri[1], 64'd102);
      end
      step();
    end
    check("t4_reports", 64'(n), 64'd5);
    drive(1'b1, 1'b0, 6'b000100, 1'b1);
    step();
    drive(1'b1, 1'b0, '0, 1'b1);
    step();
    check("t4_rehit_valid", 64'(rv[1]), 64'd1);
    check("t4_rehit_index", ri[1], 64'd102);
    step();

    // clear with a same-cycle hit; queued entries survive
    do_reset();
    drive(1'b1, 1'b0, 6'b000011, 1'b0);
    step();
    drive(1'b1, 1'b0, '0, 1'b0);
    repeat (3) step();
    drive(1'b1, 1'b1, 6'b000001, 1'b0);
    step();
    check("t5_covered0", 64'(cc[0]), 64'd0);
    check("t5_covered1", 64'(cc[1]), 64'd0);
    check("t5_drop1", 64'(dc[1]), 64'd0);
    drive(1'b1, 1'b0, '0, 1'b1);
    n = 0;
    repeat (8) begin
      if (rv[0]) n++;
      step();
    end
    check("t5_queued_delivered", 64'(n), 64'd2);

    // async reset mid-drain
    do_reset();
    drive(1'b1, 1'b0, 6'b111111, 1'b0);
    step();
    drive(1'b1, 1'b0, '0, 1'b0);
    repeat (3) step();
    check("t6_queued", 64'(rv[0]), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_drop", 64'(rv[0]), 64'd0);
    check("t6_async_drop_u1", 64'(rv[1]), 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    step();
    check("t6_count_zero", 64'(cc[0]), 64'd0);
    drive(1'b1, 1'b0, 6'b100001, 1'b1);
    step();
    drive(1'b1, 1'b0, '0, 1'b1);
    step();
    check("t6_rr_restart", ri[0], 64'd100);
    repeat (3) step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        for (int k = 0; k < 2; k++) begin
          en[k]  = ($urandom_range(0, 9) != 0);
          clr[k] = ($urandom_range(0, 39) == 0);
          vld[k] = W'($urandom_range(0, 63)) & W'($urandom_range(0, 63));
          rdy[k] = ($urandom_range(0, 2) != 0);
        end
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
